// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg
// Shared cpu types for the forwarding / hazard block:
//   regbits_t    - architectural register number
//   fwd_sel_e    - 3-bit ALU operand select code
//   hit_e        - kind of writer a source register matched (none/alu/lui/load)
//   sb_entry_t   - one scoreboard entry {valid, wsel, regwen, load, lui}
//   fwd_code()   - forward select from the EX and MEM match results
package hazard_forward_unit_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    FWD_RF         = 3'b000,
    FWD_ALU_EXMEM  = 3'b001,
    FWD_ALU_MEMWB  = 3'b010,
    FWD_UP16_EXMEM = 3'b011,
    FWD_UP16_MEMWB = 3'b100
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HIT_NONE = 2'b00,
    HIT_ALU  = 2'b01,
    HIT_LUI  = 2'b10,
    HIT_LOAD = 2'b11
  } hit_e;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     regwen;
    logic     load;
    logic     lui;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, wsel: 5'd0, regwen: 1'b0,
                                     load: 1'b0, lui: 1'b0};

  // The nearer writer (EX, landing in EX/MEM) wins over the MEM writer.
  // A load hit never reaches here at issue time because it stalls instead,
  // so it falls back to the register file.
  function automatic logic [2:0] fwd_code(input logic [1:0] ex_hit,
                                          input logic [1:0] mem_hit);
    logic [2:0] code;
    case (ex_hit)
      HIT_ALU:  code = FWD_ALU_EXMEM;
      HIT_LUI:  code = FWD_UP16_EXMEM;
      HIT_NONE: begin
        case (mem_hit)
          HIT_ALU: code = FWD_ALU_MEMWB;
          HIT_LUI: code = FWD_UP16_MEMWB;
          default: code = FWD_RF;
        endcase
      end
      default:  code = FWD_RF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// fwd_match
// Combinational compare of one source register against one scoreboard entry.
// Ports:
//   valid, wsel, regwen, load, lui  - fields of the stage entry
//   src                             - source register number
//   used                            - instruction actually reads src
//   hit                             - HIT_NONE / HIT_ALU / HIT_LUI / HIT_LOAD
module fwd_match
  import hazard_forward_unit_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] wsel,
  input  logic       regwen,
  input  logic       load,
  input  logic       lui,
  input  logic [4:0] src,
  input  logic       used,
  output logic [1:0] hit
);

  // Register 0 is hard-wired zero, so a write to it never produces a match.
  always_comb begin
    hit = HIT_NONE;
    if (used && valid && regwen && (wsel == src) && (src != 5'd0)) begin
      if (load) begin
        hit = HIT_LOAD;
      end else if (lui) begin
        hit = HIT_LUI;
      end else begin
        hit = HIT_ALU;
      end
    end else begin
      hit = HIT_NONE;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Tracks in-flight writers in EX and MEM, registers the EX-stage ALU operand
// select codes and detects load-use hazards that need a stall + bubble.
// Writers in WB are not tracked: the register file write-through covers them.
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   - forwarding from EX/MEM and MEM/WB, stalls only on loads
//   undefined - forward codes constant 000, any EX/MEM writer match stalls
// Ports:
//   CLK, RST                     - clock, synchronous active-high reset
//   id_valid                     - ID holds a real instruction
//   rs_id, rt_id                 - ID source registers
//   uses_rs_id, uses_rt_id       - source is actually read
//   wsel_id, regwen_id           - ID destination / writes register file
//   load_id, lui_id              - ID result is a load / comes from upper16
//   flush                        - redirect, kills ID and EX
//   forwarda, forwardb           - registered ALU A/B select codes
//   stall                        - combinational front-end stall
//   stall_count                  - saturating count of stalled cycles
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REGS       = 32,
  parameter int STALLCNT_W = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      id_valid,
  input  logic [$clog2(REGS)-1:0]   rs_id,
  input  logic [$clog2(REGS)-1:0]   rt_id,
  input  logic                      uses_rs_id,
  input  logic                      uses_rt_id,
  input  logic [$clog2(REGS)-1:0]   wsel_id,
  input  logic                      regwen_id,
  input  logic                      load_id,
  input  logic                      lui_id,
  input  logic                      flush,
  output logic [2:0]                forwarda,
  output logic [2:0]                forwardb,
  output logic                      stall,
  output logic [STALLCNT_W-1:0]     stall_count
);

  localparam logic [STALLCNT_W-1:0] CNT_MAX = {STALLCNT_W{1'b1}};
  localparam logic [STALLCNT_W-1:0] CNT_ONE = {{(STALLCNT_W-1){1'b0}}, 1'b1};

  sb_entry_t  ex_r;
  sb_entry_t  mem_r;
  sb_entry_t  id_entry_s;
  logic [1:0] hit_ex_rs_s;
  logic [1:0] hit_ex_rt_s;
  logic [1:0] hit_mem_rs_s;
  logic [1:0] hit_mem_rt_s;
  logic       hazard_s;
  logic       issue_s;
  logic [2:0] forwarda_r;
  logic [2:0] forwardb_r;
  logic [STALLCNT_W-1:0] stall_count_r;

  fwd_match u_match_ex_rs (
    .valid(ex_r.valid), .wsel(ex_r.wsel), .regwen(ex_r.regwen),
    .load(ex_r.load), .lui(ex_r.lui), .src(rs_id), .used(uses_rs_id),
    .hit(hit_ex_rs_s)
  );
  fwd_match u_match_ex_rt (
    .valid(ex_r.valid), .wsel(ex_r.wsel), .regwen(ex_r.regwen),
    .load(ex_r.load), .lui(ex_r.lui), .src(rt_id), .used(uses_rt_id),
    .hit(hit_ex_rt_s)
  );
  fwd_match u_match_mem_rs (
    .valid(mem_r.valid), .wsel(mem_r.wsel), .regwen(mem_r.regwen),
    .load(mem_r.load), .lui(mem_r.lui), .src(rs_id), .used(uses_rs_id),
    .hit(hit_mem_rs_s)
  );
  fwd_match u_match_mem_rt (
    .valid(mem_r.valid), .wsel(mem_r.wsel), .regwen(mem_r.regwen),
    .load(mem_r.load), .lui(mem_r.lui), .src(rt_id), .used(uses_rt_id),
    .hit(hit_mem_rt_s)
  );

  // Hazard condition: without a load-data path only loads stall; with no
  // forwarding at all every in-flight writer match has to wait for WB.
  always_comb begin
    hazard_s = 1'b0;
`ifdef HAZARD_FORWARD_EN
    hazard_s = (hit_ex_rs_s  == HIT_LOAD) || (hit_ex_rt_s  == HIT_LOAD) ||
               (hit_mem_rs_s == HIT_LOAD) || (hit_mem_rt_s == HIT_LOAD);
`else
    hazard_s = (hit_ex_rs_s  != HIT_NONE) || (hit_ex_rt_s  != HIT_NONE) ||
               (hit_mem_rs_s != HIT_NONE) || (hit_mem_rt_s != HIT_NONE);
`endif
  end

  // Stall and issue; flush and reset both override a pending stall at once.
  always_comb begin
    stall   = 1'b0;
    issue_s = 1'b0;
    if (RST || flush || !id_valid) begin
      stall   = 1'b0;
      issue_s = 1'b0;
    end else begin
      stall   = hazard_s;
      issue_s = !hazard_s;
    end
  end

  // Entry presented by ID for the EX slot.
  always_comb begin
    id_entry_s        = SB_EMPTY;
    id_entry_s.valid  = 1'b1;
    id_entry_s.wsel   = wsel_id;
    id_entry_s.regwen = regwen_id;
    id_entry_s.load   = load_id;
    id_entry_s.lui    = lui_id;
  end

  // Scoreboard shift: ID -> EX (or bubble), EX -> MEM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_r  <= SB_EMPTY;
      mem_r <= SB_EMPTY;
    end else begin
      mem_r <= ex_r;
      if (issue_s) begin
        ex_r <= id_entry_s;
      end else begin
        ex_r <= SB_EMPTY;
      end
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Forward codes computed at issue, valid while the instruction is in EX.
  always_ff @(posedge CLK) begin
    if (RST) begin
      forwarda_r <= FWD_RF;
      forwardb_r <= FWD_RF;
    end else if (issue_s) begin
      forwarda_r <= fwd_code(hit_ex_rs_s, hit_mem_rs_s);
      forwardb_r <= fwd_code(hit_ex_rt_s, hit_mem_rt_s);
    end else begin
      forwarda_r <= FWD_RF;
      forwardb_r <= FWD_RF;
    end
  end
`else
  // Without forwarding the operands always come from the register file.
  always_ff @(posedge CLK) begin
    forwarda_r <= FWD_RF;
    forwardb_r <= FWD_RF;
  end
`endif

  // Saturating stalled-cycle counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count_r <= {STALLCNT_W{1'b0}};
    end else if (stall && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign forwarda    = forwarda_r;
  assign forwardb    = forwardb_r;
  assign stall_count = stall_count_r;

endmodule
